// File: rtl/layer_5_pkg.sv
// Shared widths and FSM encoding for the final fully-connected classifier stage.
package l5_pkg;
  localparam int N_IN   = 64;
  localparam int N_OUT  = 10;
  localparam int N_LANE = 16;
  localparam int DATA_W = 18;
  localparam int W_W    = 9;
  localparam int ACC_W  = 36;
  localparam int PROD_W = DATA_W + W_W;
  localparam int ROW_W  = N_OUT * W_W;

  typedef enum logic [2:0] {IDLE, MAC, BIAS, ARGMAX, DONE} state_l5_t;
endpackage

// File: rtl/layer_5_if.sv
// Bus between layer_4 banks, the classifier and the UART/display path.
interface layer_5_if;
  import l5_pkg::*;

  logic              strt;
  logic              tx_done;
  logic [DATA_W-1:0] din [N_LANE-1:0];
  logic [1:0]        addr_rd;
  logic [3:0]        class_idx;
  logic [ACC_W-1:0]  max_logit;
  logic              rdy;

  modport slave  (input strt, tx_done, din, output addr_rd, class_idx, max_logit, rdy);
  modport master (output strt, tx_done, din, input addr_rd, class_idx, max_logit, rdy);
endinterface

// File: rtl/layer_5_rom.sv
// Synchronous ROM with registered output; contents come from a packed image parameter.
module l5_rom #(
  parameter int                     DEPTH = 64,
  parameter int                     WIDTH = 90,
  parameter int                     AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter logic [DEPTH*WIDTH-1:0] INIT  = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [AW-1:0]    addr,
  output logic [WIDTH-1:0] dout
);
  logic [WIDTH-1:0] rom [DEPTH];

  for (genvar i = 0; i < DEPTH; i++) begin : g_word
    assign rom[i] = INIT[i*WIDTH +: WIDTH];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dout <= '0;
    else        dout <= rom[addr];
  end
endmodule

// File: rtl/layer_5.sv
// Final FC layer: 64 activations x 10 outputs MAC, bias add, sequential argmax.
//   state  | meaning
//   IDLE   | waiting for strt
//   MAC    | issue rows 0..63, accumulate one cycle behind, plus one drain cycle
//   BIAS   | add bias to every accumulator
//   ARGMAX | scan acc[0..9], strict > so ties keep the lower index
//   DONE   | result registered, rdy held until tx_done
module layer_5
  import l5_pkg::*;
#(
  parameter logic [N_IN*ROW_W-1:0] W_INIT = '0,
  parameter logic [ROW_W-1:0]      B_INIT = '0
) (
  input logic      clk,
  input logic      rst_n,
  layer_5_if.slave bus
);
  state_l5_t               state;
  logic [6:0]              idx;
  logic [6:0]              idx_nxt;
  logic [3:0]              idx_d;
  logic                    mac_v;
  logic [3:0]              k;
  logic signed [ACC_W-1:0] acc [N_OUT];
  logic signed [ACC_W-1:0] best;
  logic [3:0]              best_idx;
  logic [1:0]              addr_rd;
  logic [3:0]              class_idx;
  logic [ACC_W-1:0]        max_logit;
  logic                    rdy;

  logic [ROW_W-1:0]         w_row;
  logic [ROW_W-1:0]         b_row;
  logic signed [DATA_W-1:0] din_s;
  logic signed [W_W-1:0]    w_s  [N_OUT];
  logic signed [W_W-1:0]    b_s  [N_OUT];
  logic signed [PROD_W-1:0] prod [N_OUT];

  l5_rom #(.DEPTH(N_IN), .WIDTH(ROW_W), .INIT(W_INIT)) u_w_rom (
    .clk(clk), .rst_n(rst_n), .addr(idx[5:0]), .dout(w_row)
  );

  // Single 90-bit word so all ten biases are available in the one BIAS cycle.
  l5_rom #(.DEPTH(1), .WIDTH(ROW_W), .INIT(B_INIT)) u_b_rom (
    .clk(clk), .rst_n(rst_n), .addr(1'b0), .dout(b_row)
  );

  assign din_s   = bus.din[idx_d];
  assign idx_nxt = idx + 7'd1;

  for (genvar j = 0; j < N_OUT; j++) begin : g_lane
    assign w_s[j]  = w_row[j*W_W +: W_W];
    assign b_s[j]  = b_row[j*W_W +: W_W];
    assign prod[j] = PROD_W'(din_s) * PROD_W'(w_s[j]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      idx_d     <= '0;
      mac_v     <= 1'b0;
      k         <= '0;
      best      <= '0;
      best_idx  <= '0;
      addr_rd   <= '0;
      class_idx <= '0;
      max_logit <= '0;
      rdy       <= 1'b0;
      for (int j = 0; j < N_OUT; j++) acc[j] <= '0;
    end else if (bus.tx_done) begin
      state     <= IDLE;
      idx       <= '0;
      idx_d     <= '0;
      mac_v     <= 1'b0;
      k         <= '0;
      best      <= '0;
      best_idx  <= '0;
      addr_rd   <= '0;
      class_idx <= '0;
      max_logit <= '0;
      rdy       <= 1'b0;
      for (int j = 0; j < N_OUT; j++) acc[j] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.strt) begin
            idx     <= '0;
            mac_v   <= 1'b0;
            addr_rd <= '0;
            for (int j = 0; j < N_OUT; j++) acc[j] <= '0;
            state   <= MAC;
          end
        end
        MAC: begin
          // idx reaching 64 marks the drain cycle: no issue, last accumulate.
          mac_v   <= ~idx[6];
          idx_d   <= idx[3:0];
          addr_rd <= idx_nxt[6] ? 2'd0 : idx_nxt[5:4];
          if (!idx[6]) idx <= idx_nxt;
          if (mac_v) begin
            for (int j = 0; j < N_OUT; j++) acc[j] <= acc[j] + ACC_W'(prod[j]);
          end
          if (idx[6]) state <= BIAS;
        end
        BIAS: begin
          for (int j = 0; j < N_OUT; j++) acc[j] <= acc[j] + ACC_W'(b_s[j]);
          k     <= '0;
          state <= ARGMAX;
        end
        ARGMAX: begin
          if (k == 4'd0) begin
            best     <= acc[0];
            best_idx <= 4'd0;
          end else if (acc[k] > best) begin
            best     <= acc[k];
            best_idx <= k;
          end
          k <= k + 4'd1;
          if (k == 4'(N_OUT - 1)) state <= DONE;
        end
        DONE: begin
          class_idx <= best_idx;
          max_logit <= best;
          rdy       <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.addr_rd   = addr_rd;
  assign bus.class_idx = class_idx;
  assign bus.max_logit = max_logit;
  assign bus.rdy       = rdy;
endmodule
